// File: rtl/trans_mat_stream_pkg.sv
// Shared configuration for the RGB-D visual-odometry point transform:
// default widths, the 3x4 pose container type and a pose-index helper.
package RgbdVoConfigPk;

  localparam int CLOUD_BW = 32;
  localparam int POSE_BW  = 32;
  localparam int MUL      = 24;

  // Row-major 3x4 [R|t]; indices 3, 7 and 11 hold the translation.
  typedef logic signed [POSE_BW-1:0] pose_t [12];

  function automatic logic is_diag(input int unsigned idx);
    return (idx == 0) || (idx == 5) || (idx == 10);
  endfunction

endpackage

// File: rtl/trans_mat_stream_row.sv
// One output coordinate of the rigid transform: three products, adder tree
// and width reduction. TRANS_MAT_SAT_EN selects clamping instead of wrap.
module trans_mat_row #(
  parameter int CLOUD_BW = 32,
  parameter int POSE_BW  = 32,
  parameter int FRAC_BW  = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic signed [CLOUD_BW-1:0] x,
  input  logic signed [CLOUD_BW-1:0] y,
  input  logic signed [CLOUD_BW-1:0] z,
  input  logic signed [POSE_BW-1:0]  r0,
  input  logic signed [POSE_BW-1:0]  r1,
  input  logic signed [POSE_BW-1:0]  r2,
  input  logic signed [POSE_BW-1:0]  t,
  output logic signed [CLOUD_BW-1:0] result
);

  localparam int PW = CLOUD_BW + POSE_BW;
  localparam int SW = PW + 2;

  logic signed [PW-1:0]       m0, m1, m2;
  logic signed [PW-1:0]       p0, p1, p2;
  logic signed [POSE_BW-1:0]  t2;
  logic signed [SW-1:0]       sa, sb, sum4;
  logic signed [CLOUD_BW-1:0] red;

  assign m0 = PW'(x) * PW'(r0);
  assign m1 = PW'(y) * PW'(r1);
  assign m2 = PW'(z) * PW'(r2);

`ifdef TRANS_MAT_SAT_EN
  localparam logic signed [SW-1:0] MAXV = {{(SW-CLOUD_BW+1){1'b0}}, {(CLOUD_BW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-CLOUD_BW+1){1'b1}}, {(CLOUD_BW-1){1'b0}}};

  always_comb begin
    red = sum4[CLOUD_BW-1:0];
    if (sum4 > MAXV)
      red = MAXV[CLOUD_BW-1:0];
    else if (sum4 < MINV)
      red = MINV[CLOUD_BW-1:0];
  end
`else
  always_comb begin
    red = sum4[CLOUD_BW-1:0];
  end
`endif

  // S2 products, S3 partial sums, S4 final sum, then the reduced output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0     <= '0;
      p1     <= '0;
      p2     <= '0;
      t2     <= '0;
      sa     <= '0;
      sb     <= '0;
      sum4   <= '0;
      result <= '0;
    end else if (en) begin
      p0     <= m0 >>> FRAC_BW;
      p1     <= m1 >>> FRAC_BW;
      p2     <= m2 >>> FRAC_BW;
      t2     <= t;
      sa     <= SW'(p0) + SW'(p1);
      sb     <= SW'(p2) + SW'(t2);
      sum4   <= sa + sb;
      result <= red;
    end
  end

endmodule

// File: rtl/trans_mat_stream.sv
// Streaming 3x4 rigid transform of point-cloud coordinates with a
// valid/ready handshake. Optional macro TRANS_MAT_SAT_EN clamps results.
module trans_mat_stream #(
  parameter int CLOUD_BW = RgbdVoConfigPk::CLOUD_BW,
  parameter int POSE_BW  = RgbdVoConfigPk::POSE_BW,
  parameter int FRAC_BW  = RgbdVoConfigPk::MUL
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [CLOUD_BW-1:0] i_cloud_x,
  input  logic signed [CLOUD_BW-1:0] i_cloud_y,
  input  logic signed [CLOUD_BW-1:0] i_cloud_z,
  input  logic                       i_pose_valid,
  input  logic signed [POSE_BW-1:0]  i_pose [12],
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [CLOUD_BW-1:0] o_cloud_x,
  output logic signed [CLOUD_BW-1:0] o_cloud_y,
  output logic signed [CLOUD_BW-1:0] o_cloud_z,
  output logic                       o_busy
);

  import RgbdVoConfigPk::*;

  localparam logic signed [POSE_BW-1:0] ONE = POSE_BW'(64'd1 << FRAC_BW);

  logic                       adv;
  logic [3:0]                 vld;
  logic signed [POSE_BW-1:0]  act_pose  [12];
  logic signed [POSE_BW-1:0]  snap_pose [12];
  logic signed [CLOUD_BW-1:0] s1_x, s1_y, s1_z;

  assign adv     = !(o_valid && !i_ready);
  assign o_ready = adv;
  assign o_busy  = (|vld) | o_valid;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < 12; i++)
        act_pose[i] <= is_diag(i) ? ONE : '0;
    end else if (i_pose_valid) begin
      act_pose <= i_pose;
    end
  end

  // Snapshot reads the registered pose, so a same-edge pose load is not seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld     <= '0;
      o_valid <= 1'b0;
      s1_x    <= '0;
      s1_y    <= '0;
      s1_z    <= '0;
      for (int unsigned i = 0; i < 12; i++)
        snap_pose[i] <= '0;
    end else if (adv) begin
      vld     <= {vld[2:0], i_valid};
      o_valid <= vld[3];
      if (i_valid) begin
        s1_x      <= i_cloud_x;
        s1_y      <= i_cloud_y;
        s1_z      <= i_cloud_z;
        snap_pose <= act_pose;
      end
    end
  end

  trans_mat_row #(.CLOUD_BW(CLOUD_BW), .POSE_BW(POSE_BW), .FRAC_BW(FRAC_BW)) u_row_x (
    .clk(i_clk), .rst(i_rst), .en(adv), .x(s1_x), .y(s1_y), .z(s1_z),
    .r0(snap_pose[0]), .r1(snap_pose[1]), .r2(snap_pose[2]), .t(snap_pose[3]),
    .result(o_cloud_x)
  );

  trans_mat_row #(.CLOUD_BW(CLOUD_BW), .POSE_BW(POSE_BW), .FRAC_BW(FRAC_BW)) u_row_y (
    .clk(i_clk), .rst(i_rst), .en(adv), .x(s1_x), .y(s1_y), .z(s1_z),
    .r0(snap_pose[4]), .r1(snap_pose[5]), .r2(snap_pose[6]), .t(snap_pose[7]),
    .result(o_cloud_y)
  );

  trans_mat_row #(.CLOUD_BW(CLOUD_BW), .POSE_BW(POSE_BW), .FRAC_BW(FRAC_BW)) u_row_z (
    .clk(i_clk), .rst(i_rst), .en(adv), .x(s1_x), .y(s1_y), .z(s1_z),
    .r0(snap_pose[8]), .r1(snap_pose[9]), .r2(snap_pose[10]), .t(snap_pose[11]),
    .result(o_cloud_z)
  );

endmodule

// File: tb/tb_trans_mat_stream.sv
// Self-checking bench for trans_mat_stream (CLOUD_BW=POSE_BW=32, FRAC_BW=24):
// vector table, directed handshake/reset sequences and a random stream.
module tb_trans_mat_stream;

  localparam logic signed [31:0] ONE  = 32'sh0100_0000;
  localparam logic signed [31:0] NEG1 = -32'sh0100_0000;
  localparam logic signed [31:0] HALF = 32'sh0080_0000;
  localparam logic signed [31:0] TWO  = 32'sh0200_0000;
  localparam logic signed [31:0] ONE5 = 32'sh0180_0000;
  localparam logic signed [31:0] QTR  = 32'sh0040_0000;

  typedef struct {
    logic signed [31:0] pose [12];
    logic signed [31:0] x, y, z;
    logic [31:0]        ex, ey, ez;
  } vec_t;

  typedef struct {
    logic [31:0] x, y, z;
  } pt_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               i_valid = 1'b0;
  logic               o_ready;
  logic signed [31:0] cx = '0, cy = '0, cz = '0;
  logic               pose_valid = 1'b0;
  logic signed [31:0] pose [12];
  logic               o_valid;
  logic               i_ready = 1'b1;
  logic signed [31:0] ox, oy, oz;
  logic               o_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ready_low = 0;

  logic signed [31:0] mpose [12];
  pt_t model_q [$];
  pt_t out_q [$];
  vec_t tbl [6];

  trans_mat_stream #(.CLOUD_BW(32), .POSE_BW(32), .FRAC_BW(24)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_cloud_x(cx), .i_cloud_y(cy), .i_cloud_z(cz),
    .i_pose_valid(pose_valid), .i_pose(pose),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_cloud_x(ox), .o_cloud_y(oy), .o_cloud_z(oz), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] reduce(input logic signed [65:0] a);
`ifdef TRANS_MAT_SAT_EN
    if (a > 66'sd2147483647) return 32'h7FFF_FFFF;
    if (a < -66'sd2147483648) return 32'h8000_0000;
`endif
    return a[31:0];
  endfunction

  // y = floor(r0*x/2^24) + floor(r1*y/2^24) + floor(r2*z/2^24) + t, exactly.
  function automatic logic [31:0] row_ref(input logic signed [31:0] x, y, z, r0, r1, r2, t);
    longint p0, p1, p2;
    logic signed [65:0] acc;
    p0 = longint'(x) * longint'(r0);
    p1 = longint'(y) * longint'(r1);
    p2 = longint'(z) * longint'(r2);
    acc = p0 >>> 24;
    acc = acc + (p1 >>> 24);
    acc = acc + (p2 >>> 24);
    acc = acc + t;
    return reduce(acc);
  endfunction

  task automatic set_identity_model();
    for (int i = 0; i < 12; i++)
      mpose[i] = (i == 0 || i == 5 || i == 10) ? ONE : 32'sd0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes on the falling edge, then advance.
  task automatic step();
    pt_t e, g;
    @(negedge clk);
    if (rst) begin
      model_q.delete();
      set_identity_model();
    end else begin
      if (!o_ready) ready_low++;
      if (o_valid && i_ready) begin
        g.x = ox; g.y = oy; g.z = oz;
        out_q.push_back(g);
        tests++;
        if (model_q.size() == 0) begin
          fails++;
          $display("FAIL stream_out: got unexpected point %0h %0h %0h expected none", ox, oy, oz);
        end else begin
          e = model_q.pop_front();
          if (g.x !== e.x || g.y !== e.y || g.z !== e.z) begin
            fails++;
            $display("FAIL stream_out: got %0h %0h %0h expected %0h %0h %0h",
                     g.x, g.y, g.z, e.x, e.y, e.z);
          end
        end
      end
      if (i_valid && o_ready) begin
        e.x = row_ref(cx, cy, cz, mpose[0], mpose[1], mpose[2], mpose[3]);
        e.y = row_ref(cx, cy, cz, mpose[4], mpose[5], mpose[6], mpose[7]);
        e.z = row_ref(cx, cy, cz, mpose[8], mpose[9], mpose[10], mpose[11]);
        model_q.push_back(e);
      end
      if (pose_valid) mpose = pose;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic load_pose(input logic signed [31:0] p [12]);
    pose = p;
    pose_valid = 1'b1;
    step();
    pose_valid = 1'b0;
  endtask

  task automatic send(input logic signed [31:0] x, y, z);
    cx = x; cy = y; cz = z;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int budget;
    budget = 40;
    while (out_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (out_q.size() < n) chk({name, "_timeout"}, out_q.size(), n);
  endtask

  initial begin
    logic signed [31:0] p [12];
    pt_t g;
    int acc_edge, lat, budget, seen;
    logic [31:0] sat_x, ovf_x;

`ifdef TRANS_MAT_SAT_EN
    sat_x = 32'h7FFF_FFFF;
    ovf_x = 32'h8000_0000;
`else
    sat_x = 32'hFFFF_FFFE;
    ovf_x = 32'h7FFF_FFAC;
`endif
    tbl[0].pose = '{ONE, 0, 0, -100, 0, ONE, 0, 50, 0, 0, ONE, 0};
    tbl[0].x = 32'sh8000_0010; tbl[0].y = 5; tbl[0].z = 0;
    tbl[0].ex = ovf_x; tbl[0].ey = 32'd55; tbl[0].ez = 32'd0;
    tbl[1].pose = '{ONE, 0, 0, 3, 0, ONE, 0, 0, 0, 0, ONE, -2};
    tbl[1].x = 10; tbl[1].y = 20; tbl[1].z = 30;
    tbl[1].ex = 32'd13; tbl[1].ey = 32'd20; tbl[1].ez = 32'd28;
    tbl[2].pose = '{HALF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2].x = -1; tbl[2].y = 123; tbl[2].z = 456;
    tbl[2].ex = 32'hFFFF_FFFF; tbl[2].ey = 32'd0; tbl[2].ez = 32'd0;
    tbl[3].pose = '{TWO, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3].x = 32'sh7FFF_FFFF; tbl[3].y = 9; tbl[3].z = -9;
    tbl[3].ex = sat_x; tbl[3].ey = 32'd0; tbl[3].ez = 32'd0;
    tbl[4].pose = '{0, NEG1, 0, 0, ONE, 0, 0, 0, 0, 0, ONE, 0};
    tbl[4].x = 5; tbl[4].y = 7; tbl[4].z = -3;
    tbl[4].ex = -32'sd7; tbl[4].ey = 32'd5; tbl[4].ez = -32'sd3;
    tbl[5].pose = '{ONE5, 0, 0, 0, 0, ONE5, 0, 0, 0, 0, QTR, 0};
    tbl[5].x = 3; tbl[5].y = -3; tbl[5].z = -1;
    tbl[5].ex = 32'd4; tbl[5].ey = -32'sd5; tbl[5].ez = -32'sd1;

    for (int i = 0; i < 12; i++) pose[i] = '0;
    set_identity_model();

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_o_valid", o_valid, 0);
    chk("reset_o_busy", o_busy, 0);
    chk("reset_o_ready", o_ready, 1);
    chk("reset_o_cloud", {ox, oy}, 64'd0);
    chk("reset_o_cloud_z", oz, 0);

    // Identity pose straight out of reset, and the four-edge latency.
    cx = 100; cy = -5; cz = 7; i_valid = 1'b1;
    step();
    acc_edge = cyc;
    i_valid = 1'b0;
    budget = 20;
    while (!o_valid && budget > 0) begin
      step();
      budget--;
    end
    lat = cyc - acc_edge;
    chk("latency", lat, 4);
    out_q.delete();
    wait_outputs(1, "ident");
    g = out_q.pop_front();
    chk("ident_x", g.x, 32'd100);
    chk("ident_y", g.y, 32'hFFFF_FFFB);
    chk("ident_z", g.z, 32'd7);

    for (int v = 0; v < 6; v++) begin
      load_pose(tbl[v].pose);
      out_q.delete();
      send(tbl[v].x, tbl[v].y, tbl[v].z);
      wait_outputs(1, $sformatf("vec%0d", v));
      if (out_q.size() > 0) begin
        g = out_q.pop_front();
        chk($sformatf("vec%0d_x", v), g.x, tbl[v].ex);
        chk($sformatf("vec%0d_y", v), g.y, tbl[v].ey);
        chk($sformatf("vec%0d_z", v), g.z, tbl[v].ez);
      end
    end

    // Five back-to-back points with a three-cycle downstream stall.
    load_pose('{ONE, 0, 0, 3, 0, ONE, 0, 0, 0, 0, ONE, -2});
    out_q.delete();
    ready_low = 0;
    for (int s = 0; s < 20; s++) begin
      i_valid = (s < 5);
      cx = s * 10; cy = -s; cz = s;
      i_ready = !(s >= 6 && s <= 8);
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    chk("stall_count_out", out_q.size(), 5);
    chk("stall_ready_low", ready_low, 3);
    for (int k = 0; k < 5 && out_q.size() > 0; k++) begin
      g = out_q.pop_front();
      chk($sformatf("stall_pt%0d", k), {g.x, g.z}, {32'(k * 10 + 3), 32'(k - 2)});
    end

    // Pose pulse on the same edge as a point's acceptance.
    load_pose('{ONE, 0, 0, 0, 0, ONE, 0, 0, 0, 0, ONE, 0});
    out_q.delete();
    cx = 1; cy = 2; cz = 3; i_valid = 1'b1;
    pose = '{ONE, 0, 0, 10, 0, ONE, 0, 20, 0, 0, ONE, 30};
    pose_valid = 1'b1;
    step();
    pose_valid = 1'b0;
    step();
    i_valid = 1'b0;
    wait_outputs(2, "pose_edge");
    if (out_q.size() >= 2) begin
      g = out_q.pop_front();
      chk("pose_edge_old", {g.x, g.y}, {32'd1, 32'd2});
      g = out_q.pop_front();
      chk("pose_edge_new", {g.x, g.z}, {32'd11, 32'd33});
    end

    // Reset with three points in flight.
    load_pose('{ONE, 0, 0, 7, 0, ONE, 0, 7, 0, 0, ONE, 7});
    out_q.delete();
    for (int s = 0; s < 3; s++) begin
      cx = 40 + s; cy = 0; cz = 0; i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("midrst_busy", o_busy, 0);
    seen = 0;
    for (int s = 0; s < 8; s++) begin
      if (o_valid) seen++;
      step();
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_outs", out_q.size(), 0);
    send(4, 5, 6);
    wait_outputs(1, "midrst_pose");
    if (out_q.size() > 0) begin
      g = out_q.pop_front();
      chk("midrst_identity", {g.x, g.z}, {32'd4, 32'd6});
    end

    // Random stream against the reference model.
    for (int s = 0; s < 600; s++) begin
      i_valid = ($urandom % 4) != 0;
      i_ready = ($urandom % 4) != 0;
      cx = $urandom; cy = $urandom; cz = $urandom;
      if (($urandom % 12) == 0) begin
        p = pose;
        for (int i = 0; i < 12; i++)
          p[i] = (i % 4 == 3) ? $signed($urandom) >>> ($urandom % 16)
                              : $signed($urandom) >>> (4 + $urandom % 6);
        pose = p;
        pose_valid = 1'b1;
      end else begin
        pose_valid = 1'b0;
      end
      step();
    end
    i_valid = 1'b0;
    pose_valid = 1'b0;
    i_ready = 1'b1;
    budget = 30;
    while ((model_q.size() != 0 || o_busy) && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_model_empty", model_q.size(), 0);
    chk("drain_busy", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
